// File: rtl/pipe_hazard_ctrl.sv
// Purpose: pipeline hazard controller with stall/freeze/flush generation, a stall watchdog and perf counters.
// Latency: hold/flush outputs are combinational in the same cycle; hz_state, counters and hazard_err update on the next edge.
// Backpressure: dmem_busy freezes the whole pipe and outranks hazards; the watchdog parks the pipe in ERR until reset.
module pipe_hazard_ctrl #(
    parameter int RW        = 5,
    parameter int CNT_W     = 16,
    parameter int BR_IN_ID  = 1,
    parameter int MAX_STALL = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_ex_memread,
    input  logic             id_ex_regwrite,
    input  logic             id_ex_regdst,
    input  logic [RW-1:0]    id_ex_rt,
    input  logic [RW-1:0]    id_ex_rd,
    input  logic             ex_mem_memread,
    input  logic [RW-1:0]    ex_mem_rd,
    input  logic [RW-1:0]    if_id_rs,
    input  logic [RW-1:0]    if_id_rt,
    input  logic             beq,
    input  logic             bne,
    input  logic             jump,
    input  logic             if_equal,
    input  logic             dmem_busy,
    output logic             pc_hold,
    output logic             if_id_hold,
    output logic             id_ex_flush,
    output logic             if_flush,
    output logic             ex_mem_hold,
    output logic             hazard_err,
    output logic [1:0]       hz_state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        STALL  = 2'd1,
        FREEZE = 2'd2,
        ERR    = 2'd3
    } state_t;

    // run_len only ever needs to reach MAX_STALL-1 before the watchdog fires
    localparam int RL_W = (MAX_STALL > 1) ? $clog2(MAX_STALL) : 1;
    localparam logic [RL_W-1:0] RL_LIMIT = (MAX_STALL > 0) ? RL_W'(MAX_STALL - 1) : '0;
    localparam logic WD_EN = (MAX_STALL > 0);
    localparam logic BR_EN = (BR_IN_ID != 0);

    state_t           state_q, state_d;
    logic [RL_W-1:0]  run_len_q, run_len_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic [RW-1:0] ex_dest;
    logic          is_br;
    logic          ld_use, br_alu, br_ld;
    logic          hz, frz, taken;
    logic          in_err, hold, wd_fire;

    // Hazard detection; register 0 never creates a dependency
    always_comb begin
        ex_dest = id_ex_regdst ? id_ex_rd : id_ex_rt;
        is_br   = BR_EN & (beq | bne);
        ld_use  = id_ex_memread & (id_ex_rt != '0) &
                  ((id_ex_rt == if_id_rs) | (id_ex_rt == if_id_rt));
        br_alu  = is_br & id_ex_regwrite & (ex_dest != '0) &
                  ((ex_dest == if_id_rs) | (ex_dest == if_id_rt));
        br_ld   = is_br & ex_mem_memread & (ex_mem_rd != '0) &
                  ((ex_mem_rd == if_id_rs) | (ex_mem_rd == if_id_rt));
        hz      = ld_use | br_alu | br_ld;
        frz     = dmem_busy;
        taken   = jump | (BR_EN & ((beq & if_equal) | (bne & ~if_equal)));
    end

    // Pipeline control outputs; ERR forces a full hold with no flushes
    always_comb begin
        in_err      = (state_q == ERR);
        hold        = in_err | hz | frz;
        pc_hold     = hold;
        if_id_hold  = hold;
        ex_mem_hold = in_err | frz;
        id_ex_flush = ~in_err & hz & ~frz;
        if_flush    = ~in_err & taken & ~hz & ~frz;
        hazard_err  = in_err;
        wd_fire     = WD_EN & ~in_err & hold & (run_len_q == RL_LIMIT);
    end

    // Next-state: FSM, held-run length and saturating counters, all frozen in ERR
    always_comb begin
        state_d     = state_q;
        run_len_d   = run_len_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!in_err) begin
            if (wd_fire) begin
                state_d = ERR;
            end else if (frz) begin
                state_d = FREEZE;
            end else if (hz) begin
                state_d = STALL;
            end else begin
                state_d = RUN;
            end
            if (hold) begin
                if (run_len_q != '1) begin
                    run_len_d = run_len_q + 1'b1;
                end
            end else begin
                run_len_d = '0;
            end
            if (hz && !frz && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
            if (if_flush && (flush_cnt_q != '1)) begin
                flush_cnt_d = flush_cnt_q + 1'b1;
            end
        end
    end

    // State registers with synchronous reset overriding ERR
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            run_len_q   <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            run_len_q   <= run_len_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz_state  = state_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Purpose: bench for pipe_hazard_ctrl; two instances (default params, and CNT_W=2/MAX_STALL=4/no ID branches).
// Latency: control outputs checked in-cycle, state and counters checked after each edge.
// Backpressure: dmem_busy freezes and watchdog trips exercised directly and by random stimulus.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_ex_memread, id_ex_regwrite, id_ex_regdst;
    logic [4:0] id_ex_rt, id_ex_rd, ex_mem_rd, if_id_rs, if_id_rt;
    logic       ex_mem_memread, beq, bne, jump, if_equal, dmem_busy;

    logic        d0_pc, d0_ifid, d0_idex, d0_iff, d0_exm, d0_herr;
    logic [1:0]  d0_st;
    logic [15:0] d0_sc, d0_fc;
    logic        d1_pc, d1_ifid, d1_idex, d1_iff, d1_exm, d1_herr;
    logic [1:0]  d1_st;
    logic [1:0]  d1_sc, d1_fc;

    logic [5:0]  o_ctl [2];
    logic [1:0]  o_st  [2];
    logic [15:0] o_sc  [2];
    logic [15:0] o_fc  [2];

    int n_chk  = 0;
    int n_fail = 0;

    // reference model state, one slot per instance
    int MS [2];
    int CM [2];
    bit BRK [2];
    bit m_err [2];
    int m_run [2];
    int m_state [2];
    int m_stall [2];
    int m_flush [2];
    bit m_valid = 1'b0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.RW(5), .CNT_W(16), .BR_IN_ID(1), .MAX_STALL(16)) dut0 (
        .clk(clk), .reset(reset),
        .id_ex_memread(id_ex_memread), .id_ex_regwrite(id_ex_regwrite), .id_ex_regdst(id_ex_regdst),
        .id_ex_rt(id_ex_rt), .id_ex_rd(id_ex_rd),
        .ex_mem_memread(ex_mem_memread), .ex_mem_rd(ex_mem_rd),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
        .beq(beq), .bne(bne), .jump(jump), .if_equal(if_equal), .dmem_busy(dmem_busy),
        .pc_hold(d0_pc), .if_id_hold(d0_ifid), .id_ex_flush(d0_idex), .if_flush(d0_iff),
        .ex_mem_hold(d0_exm), .hazard_err(d0_herr), .hz_state(d0_st),
        .stall_cnt(d0_sc), .flush_cnt(d0_fc)
    );

    pipe_hazard_ctrl #(.RW(5), .CNT_W(2), .BR_IN_ID(0), .MAX_STALL(4)) dut1 (
        .clk(clk), .reset(reset),
        .id_ex_memread(id_ex_memread), .id_ex_regwrite(id_ex_regwrite), .id_ex_regdst(id_ex_regdst),
        .id_ex_rt(id_ex_rt), .id_ex_rd(id_ex_rd),
        .ex_mem_memread(ex_mem_memread), .ex_mem_rd(ex_mem_rd),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
        .beq(beq), .bne(bne), .jump(jump), .if_equal(if_equal), .dmem_busy(dmem_busy),
        .pc_hold(d1_pc), .if_id_hold(d1_ifid), .id_ex_flush(d1_idex), .if_flush(d1_iff),
        .ex_mem_hold(d1_exm), .hazard_err(d1_herr), .hz_state(d1_st),
        .stall_cnt(d1_sc), .flush_cnt(d1_fc)
    );

    assign o_ctl[0] = {d0_pc, d0_ifid, d0_idex, d0_iff, d0_exm, d0_herr};
    assign o_ctl[1] = {d1_pc, d1_ifid, d1_idex, d1_iff, d1_exm, d1_herr};
    assign o_st[0]  = d0_st;
    assign o_st[1]  = d1_st;
    assign o_sc[0]  = d0_sc;
    assign o_sc[1]  = {14'd0, d1_sc};
    assign o_fc[0]  = d0_fc;
    assign o_fc[1]  = {14'd0, d1_fc};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // expected {pc_hold, if_id_hold, id_ex_flush, if_flush, ex_mem_hold, hazard_err} from current inputs
    function automatic logic [5:0] exp_ctl(input int k, output bit hz_o, output bit frz_o);
        int dest;
        bit brc, lu, ba, bl, tk, h, f;
        dest  = id_ex_regdst ? int'(id_ex_rd) : int'(id_ex_rt);
        brc   = BRK[k] && (beq || bne);
        lu    = id_ex_memread && (id_ex_rt != 0) && (id_ex_rt == if_id_rs || id_ex_rt == if_id_rt);
        ba    = brc && id_ex_regwrite && (dest != 0) && (dest == int'(if_id_rs) || dest == int'(if_id_rt));
        bl    = brc && ex_mem_memread && (ex_mem_rd != 0) && (ex_mem_rd == if_id_rs || ex_mem_rd == if_id_rt);
        h     = lu || ba || bl;
        f     = dmem_busy;
        tk    = jump || (BRK[k] && ((beq && if_equal) || (bne && !if_equal)));
        hz_o  = h;
        frz_o = f;
        if (m_err[k]) return 6'b110010 | 6'b000001;
        return {h || f, h || f, h && !f, tk && !h && !f, f, 1'b0};
    endfunction

    task automatic check_now();
        logic [5:0] e;
        bit h, f;
        for (int k = 0; k < 2; k++) begin
            e = exp_ctl(k, h, f);
            chk($sformatf("ctl%0d", k), o_ctl[k], e);
            chk($sformatf("state%0d", k), o_st[k], m_state[k]);
            chk($sformatf("stall_cnt%0d", k), o_sc[k], m_stall[k]);
            chk($sformatf("flush_cnt%0d", k), o_fc[k], m_flush[k]);
        end
    endtask

    task automatic model_step();
        logic [5:0] e;
        bit h, f, fire;
        for (int k = 0; k < 2; k++) begin
            e = exp_ctl(k, h, f);
            if (reset) begin
                m_err[k] = 0; m_run[k] = 0; m_state[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
            end else if (!m_err[k]) begin
                fire = (MS[k] > 0) && e[5] && (m_run[k] == MS[k] - 1);
                m_run[k] = e[5] ? m_run[k] + 1 : 0;
                if (h && !f && m_stall[k] < CM[k]) m_stall[k]++;
                if (e[2] && m_flush[k] < CM[k]) m_flush[k]++;
                m_state[k] = fire ? 3 : (f ? 2 : (h ? 1 : 0));
                m_err[k] = fire;
            end
        end
        if (reset) m_valid = 1'b1;
    endtask

    // inputs change just after a falling edge; one call spans exactly one rising edge
    task automatic cycle();
        #1;
        if (m_valid) check_now();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_idle();
        id_ex_memread = 0; id_ex_regwrite = 0; id_ex_regdst = 0;
        id_ex_rt = 0; id_ex_rd = 0; ex_mem_memread = 0; ex_mem_rd = 0;
        if_id_rs = 0; if_id_rt = 0; beq = 0; bne = 0; jump = 0; if_equal = 0; dmem_busy = 0;
    endtask

    initial begin
        MS[0] = 16; CM[0] = 65535; BRK[0] = 1;
        MS[1] = 4;  CM[1] = 3;     BRK[1] = 0;
        set_idle();
        reset = 1;
        cycle();
        cycle();
        reset = 0;
        #1;
        chk("rst_state0", d0_st, 0);
        chk("rst_state1", d1_st, 0);
        chk("rst_cnt0", {d0_sc, d0_fc}, 0);
        chk("rst_err1", d1_herr, 0);

        // load-use on rs
        id_ex_memread = 1; id_ex_rt = 8; if_id_rs = 8;
        #1;
        chk("lu_hold", {d0_pc, d0_ifid, d0_idex, d0_iff}, 4'b1110);
        cycle();
        chk("lu_state", d0_st, 1);
        chk("lu_scnt", d0_sc, 1);

        // zero register is never a hazard
        id_ex_rt = 0; if_id_rs = 0;
        #1;
        chk("zr_ctl", o_ctl[0], 0);
        cycle();
        chk("zr_state", d0_st, 0);

        // branch after load: two stall cycles then the branch is taken
        set_idle();
        beq = 1; id_ex_memread = 1; id_ex_rt = 9; if_id_rt = 9;
        #1;
        chk("bl1_hold", d0_pc, 1);
        cycle();
        id_ex_memread = 0; ex_mem_memread = 1; ex_mem_rd = 9;
        #1;
        chk("bl2_hold", {d0_pc, d0_idex}, 2'b11);
        cycle();
        ex_mem_memread = 0; if_equal = 1;
        #1;
        chk("bl3_flush", d0_iff, 1);
        cycle();
        chk("bl3_fcnt", d0_fc, 1);

        // freeze outranks a load-use hazard
        set_idle();
        dmem_busy = 1; id_ex_memread = 1; id_ex_rt = 8; if_id_rs = 8;
        #1;
        chk("fz_ctl", {d0_pc, d0_exm, d0_idex}, 3'b110);
        cycle();
        chk("fz_state", d0_st, 2);
        chk("fz_scnt", d0_sc, 3);

        // watchdog on the MAX_STALL=4 instance
        set_idle();
        reset = 1;
        cycle();
        reset = 0;
        dmem_busy = 1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk($sformatf("wd_state_%0d", i), d1_st, (i < 3) ? 2 : 3);
        end
        chk("wd_err", d1_herr, 1);
        chk("wd_d0_state", d0_st, 2);
        dmem_busy = 0;
        cycle();
        cycle();
        chk("wd_sticky", {d1_herr, d1_pc, d1_exm, d1_idex, d1_iff, d1_st}, 7'b1110011);
        reset = 1;
        cycle();
        reset = 0;
        chk("wd_clear", {d1_herr, d1_st}, 3'b000);

        // 5 load-use stalls, broken once so the watchdog stays quiet
        set_idle();
        id_ex_memread = 1; id_ex_rt = 8; if_id_rs = 8;
        for (int i = 0; i < 3; i++) cycle();
        id_ex_memread = 0;
        cycle();
        id_ex_memread = 1;
        cycle();
        cycle();
        chk("sat_scnt1", d1_sc, 3);
        chk("sat_scnt0", d0_sc, 5);
        chk("sat_err1", d1_herr, 0);

        // random traffic against the model
        for (int i = 0; i < 800; i++) begin
            reset          = ($urandom_range(0, 39) == 0);
            id_ex_memread  = ($urandom_range(0, 2) == 0);
            id_ex_regwrite = ($urandom_range(0, 1) == 0);
            id_ex_regdst   = ($urandom_range(0, 1) == 0);
            id_ex_rt       = 5'($urandom_range(0, 3));
            id_ex_rd       = 5'($urandom_range(0, 3));
            ex_mem_memread = ($urandom_range(0, 2) == 0);
            ex_mem_rd      = 5'($urandom_range(0, 3));
            if_id_rs       = 5'($urandom_range(0, 3));
            if_id_rt       = 5'($urandom_range(0, 3));
            beq            = ($urandom_range(0, 2) == 0);
            bne            = ($urandom_range(0, 2) == 0);
            jump           = ($urandom_range(0, 3) == 0);
            if_equal       = ($urandom_range(0, 1) == 0);
            dmem_busy      = ($urandom_range(0, 4) == 0);
            cycle();
        end
        reset = 0;
        set_idle();
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
